// File: rtl/sr_drv_pkg.sv
// Shared types and S/R excitation encodings for the SR pattern driver.
package sr_drv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   // {S,R} excitation codes; S=R=1 has no code on purpose
   localparam logic [1:0] EXC_HOLD = 2'b00;
   localparam logic [1:0] EXC_SET  = 2'b10;
   localparam logic [1:0] EXC_RST  = 2'b01;

endpackage : sr_drv_pkg

// File: rtl/sr_excite.sv
// Maps (current Q, target bit) to a legal {S,R} excitation.
module sr_excite
   import sr_drv_pkg::*;
(
   input  logic       q,
   input  logic       t,
   input  logic       first,
   input  logic       hold_opt,
   output logic [1:0] sr_c
);

   // First bit is always explicit since Q is unknown; otherwise hold only when allowed and no change
   always_comb begin
      sr_c = EXC_HOLD;
      if (first || (q != t) || !hold_opt) begin
         sr_c = t ? EXC_SET : EXC_RST;
      end
   end

endmodule : sr_excite

// File: rtl/sr_pattern_driver.sv
// Drives an SR flip-flop so its Q follows a requested bit pattern, LSB first,
// and counts bits whose Q feedback did not match the target.
module sr_pattern_driver
   import sr_drv_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned HOLD_OPT = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [WIDTH-1:0]           pattern,
   input  logic                       Q,
   output logic                       S,
   output logic                       R,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(WIDTH+1)-1:0] err_count,
   output logic                       err_flag,
   output logic [$clog2(WIDTH)-1:0]   first_err_idx
);

   localparam int unsigned CW = $clog2(WIDTH+1);
   localparam int unsigned IW = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [CW-1:0]    err_cnt_d;
   logic [IW-1:0]    first_err_d;
   logic [1:0]       sr_d;
   logic             exc_first_c;
   logic             exc_t_c;
   logic [1:0]       exc_sr_c;

   // Excitation source: bit 0 of the live pattern at start, next queued bit after a check
   assign exc_first_c = (state_q == IDLE);
   assign exc_t_c     = exc_first_c ? pattern[0] : pat_q[1];

   sr_excite u_excite (
      .q        (Q),
      .t        (exc_t_c),
      .first    (exc_first_c),
      .hold_opt (HOLD_OPT != 0),
      .sr_c     (exc_sr_c)
   );

   // Next-state, next-excitation and error bookkeeping
   always_comb begin
      state_d     = state_q;
      pat_d       = pat_q;
      idx_d       = idx_q;
      err_cnt_d   = err_count;
      first_err_d = first_err_idx;
      sr_d        = EXC_HOLD;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = DRIVE;
               pat_d       = pattern;
               idx_d       = '0;
               err_cnt_d   = '0;
               first_err_d = '0;
               sr_d        = exc_sr_c;
            end
         end
         DRIVE: begin
            state_d = CHECK;
         end
         CHECK: begin
            if (Q != pat_q[0]) begin
               if (err_count != CW'(WIDTH)) begin
                  err_cnt_d = err_count + CW'(1);
               end
               if (err_count == '0) begin
                  first_err_d = idx_q;
               end
            end
            if (idx_q == IW'(WIDTH-1)) begin
               state_d = DONE;
            end else begin
               state_d = DRIVE;
               idx_d   = idx_q + IW'(1);
               pat_d   = pat_q >> 1;
               sr_d    = exc_sr_c;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         pat_q         <= '0;
         idx_q         <= '0;
         err_count     <= '0;
         err_flag      <= 1'b0;
         first_err_idx <= '0;
         S             <= 1'b0;
         R             <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         state_q       <= state_d;
         pat_q         <= pat_d;
         idx_q         <= idx_d;
         err_count     <= err_cnt_d;
         err_flag      <= (err_cnt_d != '0);
         first_err_idx <= first_err_d;
         S             <= sr_d[1];
         R             <= sr_d[0];
         busy          <= (state_d == DRIVE) || (state_d == CHECK);
         done          <= (state_d == DONE);
      end
   end

endmodule : sr_pattern_driver

// File: tb/tb_sr_pattern_driver.sv
// Bench for sr_pattern_driver: two instances (hold / no-hold) each fed by its own
// SR flip-flop model, or by Q tied low/high for error injection.
module tb_sr_pattern_driver;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] pattern;
   int           mode;           // 0: real flip-flop, 1: Q tied 0, 2: Q tied 1
   logic         ff1, ff0;
   logic         q1, q0;

   logic s1, r1, busy1, done1, ef1;
   logic s0, r0, busy0, done0, ef0;
   logic [3:0] ec1, ec0;
   logic [2:0] fi1, fi0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   assign q1 = (mode == 0) ? ff1 : (mode == 2);
   assign q0 = (mode == 0) ? ff0 : (mode == 2);

   // Behavioural sr_flip for each instance
   always @(posedge clk) begin
      if (s1) ff1 <= 1'b1; else if (r1) ff1 <= 1'b0;
      if (s0) ff0 <= 1'b1; else if (r0) ff0 <= 1'b0;
   end

   sr_pattern_driver #(.WIDTH(W), .HOLD_OPT(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern), .Q(q1),
      .S(s1), .R(r1), .busy(busy1), .done(done1),
      .err_count(ec1), .err_flag(ef1), .first_err_idx(fi1));

   sr_pattern_driver #(.WIDTH(W), .HOLD_OPT(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern), .Q(q0),
      .S(s0), .R(r0), .busy(busy0), .done(done0),
      .err_count(ec0), .err_flag(ef0), .first_err_idx(fi0));

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // S and R must never be high together
   always @(negedge clk) begin
      chk("sr_excl_hold", int'(s1 & r1), 0);
      chk("sr_excl_nohold", int'(s0 & r0), 0);
   end

   // Reference: Q observed at each check is the target (real FF) or the tie value
   function automatic int model_errs(input logic [W-1:0] p, input int md, output int first);
      int n = 0;
      first = 0;
      for (int i = 0; i < int'(W); i++) begin
         if (md != 0 && int'(p[i]) != ((md == 2) ? 1 : 0)) begin
            if (n == 0) first = i;
            n++;
         end
      end
      return n;
   endfunction

   task automatic chk_outputs_zero(input string nm);
      chk({nm, "_S1"}, int'(s1), 0);       chk({nm, "_R1"}, int'(r1), 0);
      chk({nm, "_busy1"}, int'(busy1), 0); chk({nm, "_done1"}, int'(done1), 0);
      chk({nm, "_ec1"}, int'(ec1), 0);     chk({nm, "_ef1"}, int'(ef1), 0);
      chk({nm, "_fi1"}, int'(fi1), 0);
      chk({nm, "_S0"}, int'(s0), 0);       chk({nm, "_busy0"}, int'(busy0), 0);
      chk({nm, "_ec0"}, int'(ec0), 0);
   endtask

   // One run, called at a falling edge; poke = edge offset (from k) where a stray start is sampled
   task automatic run(input logic [W-1:0] p, input int md, input int exp_err,
                      input int exp_first, input int poke);
      int i, qp;
      logic ex;
      logic [1:0] e1, e0;
      mode    = md;
      pattern = p;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      pattern = W'($urandom);
      for (int c = 0; c <= 2*int'(W)+1; c++) begin
         if (c < 2*int'(W) && (c % 2) == 0) begin
            i  = c / 2;
            qp = (i == 0) ? 0 : ((md == 0) ? int'(p[i-1]) : ((md == 2) ? 1 : 0));
            ex = (i == 0) || (qp != int'(p[i]));
            e1 = ex ? {p[i], ~p[i]} : 2'b00;
            e0 = {p[i], ~p[i]};
         end else begin
            e1 = 2'b00;
            e0 = 2'b00;
         end
         chk("S_hold", int'(s1), int'(e1[1]));
         chk("R_hold", int'(r1), int'(e1[0]));
         chk("S_nohold", int'(s0), int'(e0[1]));
         chk("R_nohold", int'(r0), int'(e0[0]));
         chk("busy", int'(busy1), (c < 2*int'(W)) ? 1 : 0);
         chk("done", int'(done1), (c == 2*int'(W)) ? 1 : 0);
         chk("done_nohold", int'(done0), (c == 2*int'(W)) ? 1 : 0);
         start = (c == poke - 1);
         if (start) pattern = W'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      chk("err_count", int'(ec1), exp_err);
      chk("err_flag", int'(ef1), (exp_err != 0) ? 1 : 0);
      chk("first_err_idx", int'(fi1), exp_first);
      chk("err_count_nohold", int'(ec0), exp_err);
      chk("first_err_idx_nohold", int'(fi0), exp_first);
   endtask

   typedef struct {
      logic [W-1:0] p;
      int           md;
      int           err;
      int           first;
      int           poke;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int n_err, n_first;
      tbl[0] = '{8'hA5, 0, 0, 0, -1};
      tbl[1] = '{8'hFF, 0, 0, 0, -1};
      tbl[2] = '{8'h0F, 1, 4, 0, -1};
      tbl[3] = '{8'hF0, 2, 4, 0, -1};
      tbl[4] = '{8'hA5, 0, 0, 0, 5};
      tbl[5] = '{8'h3C, 0, 0, 0, 2*W+1};
      tbl[6] = '{8'h80, 1, 1, 7, -1};
      tbl[7] = '{8'hFE, 1, 7, 1, -1};
      tbl[8] = '{8'h00, 2, 8, 0, -1};
      tbl[9] = '{8'h7E, 2, 2, 0, -1};

      rst = 1'b1; start = 1'b0; pattern = '0; mode = 0;
      ff1 = 1'b0; ff0 = 1'b0;
      #3;
      chk_outputs_zero("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      foreach (tbl[v]) run(tbl[v].p, tbl[v].md, tbl[v].err, tbl[v].first, tbl[v].poke);

      // Asynchronous reset in the middle of bit 3, then a clean run
      mode = 0; pattern = 8'hA5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      chk("bit3_R_before_rst", int'(r1), 1);
      #2 rst = 1'b1;
      #1 chk_outputs_zero("midrun_rst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_after_rst", int'(busy1), 0);
      run(8'h3C, 0, 0, 0, -1);

      // Randomized runs against the reference model
      for (int r = 0; r < 20; r++) begin
         logic [W-1:0] rp;
         int rm, pk;
         rp = W'($urandom);
         rm = int'($urandom_range(2, 0));
         pk = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2*W+1, 1)) : -1;
         n_err = model_errs(rp, rm, n_first);
         run(rp, rm, n_err, n_first, pk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_sr_pattern_driver
